// File: rtl/mul_arbiter.sv
// Two-requester arbiter that shares one iterative shift-add multiplier, with round-robin grant.
// Define MUL_ARBITER_SIGNED_EN to get two's complement operands and result; the default build is unsigned.
module mul_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iReq0,
  input  logic               iReq1,
  input  logic [WIDTH-1:0]   iA0,
  input  logic [WIDTH-1:0]   iB0,
  input  logic [WIDTH-1:0]   iA1,
  input  logic [WIDTH-1:0]   iB1,
  output logic               oDone0,
  output logic               oDone1,
  output logic [2*WIDTH-1:0] oResult,
  output logic               oBusy,
  output logic               oOwner
);

  // state | meaning
  // IDLE  | waiting for a request; grant and latch operands on the next edge
  // RUN   | one multiplier bit per cycle, LSB first, WIDTH cycles
  // DONE  | publish product, pulse owner's done, record last-served
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             state;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               last_served;

  logic               req_any;
  logic               grant_idx;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;

  assign req_any   = iReq0 | iReq1;
  // On a tie, serve whoever was not served last.
  assign grant_idx = (iReq0 & iReq1) ? ~last_served : iReq1;
  assign sel_a     = grant_idx ? iA1 : iA0;
  assign sel_b     = grant_idx ? iB1 : iB0;

`ifdef MUL_ARBITER_SIGNED_EN
  logic             sign;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             sign_n;

  // The most negative value negates to itself, which is its correct unsigned magnitude.
  assign mag_a  = sel_a[WIDTH-1] ? ({WIDTH{1'b0}} - sel_a) : sel_a;
  assign mag_b  = sel_b[WIDTH-1] ? ({WIDTH{1'b0}} - sel_b) : sel_b;
  assign sign_n = sel_a[WIDTH-1] ^ sel_b[WIDTH-1];
`endif

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state       <= IDLE;
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      cnt         <= '0;
      last_served <= 1'b1;
      oDone0      <= 1'b0;
      oDone1      <= 1'b0;
      oResult     <= '0;
      oBusy       <= 1'b0;
      oOwner      <= 1'b0;
`ifdef MUL_ARBITER_SIGNED_EN
      sign        <= 1'b0;
`endif
    end else begin
      oDone0 <= 1'b0;
      oDone1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req_any) begin
            oOwner <= grant_idx;
            acc    <= '0;
            cnt    <= '0;
            oBusy  <= 1'b1;
            state  <= RUN;
`ifdef MUL_ARBITER_SIGNED_EN
            mcand  <= {{WIDTH{1'b0}}, mag_a};
            mplier <= mag_b;
            sign   <= sign_n;
`else
            mcand  <= {{WIDTH{1'b0}}, sel_a};
            mplier <= sel_b;
`endif
          end
        end
        RUN: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state <= DONE;
        end
        DONE: begin
`ifdef MUL_ARBITER_SIGNED_EN
          oResult <= sign ? ({2*WIDTH{1'b0}} - acc) : acc;
`else
          oResult <= acc;
`endif
          oDone0      <= ~oOwner;
          oDone1      <= oOwner;
          last_served <= oOwner;
          oBusy       <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          oBusy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, setting the operand width in bits; the product width is 2*WIDTH.
REQ-002 The block SHALL have port Clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have ports iReq0 and iReq1, input, 1 bit each: request from requester 0 and requester 1.
REQ-005 The block SHALL have ports iA0 and iB0, input, WIDTH each: operands of requester 0.
REQ-006 The block SHALL have ports iA1 and iB1, input, WIDTH each: operands of requester 1.
REQ-007 The block SHALL have ports oDone0 and oDone1, output, 1 bit each: one-cycle completion pulse to the owning requester.
REQ-008 The block SHALL have port oResult, output, 2*WIDTH: product of the last completed transaction.
REQ-009 The block SHALL have port oBusy, output, 1 bit: high in RUN and DONE.
REQ-010 The block SHALL have port oOwner, output, 1 bit: index of the requester being served or last served.

Function
REQ-011 The block SHALL implement the FSM IDLE -> RUN -> DONE -> IDLE, sharing one iterative shift-add multiplier between two requesters.
REQ-012 In IDLE with no request, the block SHALL stay in IDLE with all outputs held.
REQ-013 In IDLE with exactly one iReqN high, the block SHALL grant requester N.
REQ-014 In IDLE with both requests high, the block SHALL grant the requester not equal to the last-served index (round-robin).
REQ-015 On grant, the block SHALL latch iAN/iBN, set oOwner=N, clear the accumulator and the bit counter, and enter RUN.
REQ-016 In RUN, the block SHALL process one multiplier bit per cycle (LSB first), adding the shifted multiplicand to the accumulator when the bit is 1.
REQ-017 In RUN, the block SHALL go to DONE after exactly WIDTH cycles.
REQ-018 In DONE, the block SHALL load oResult, pulse oDoneN for one cycle only to the owner, record the owner as last-served, and return to IDLE.
REQ-019 Latency: when the grant happens at edge k, oDoneN and the new oResult SHALL be visible after edge k+WIDTH+1; one transaction SHALL occupy WIDTH+2 cycles including the IDLE cycle.
REQ-020 oResult SHALL hold its value until the next DONE.
REQ-021 Operands SHALL be sampled only at grant; operand changes during RUN SHALL NOT affect the result.
REQ-022 If iReqN is deasserted during RUN, the block SHALL still complete the transaction and pulse oDoneN.
REQ-023 Handshake: a requester SHALL drop iReqN in the cycle after oDoneN; if iReqN is still high when IDLE is re-entered, the block SHALL treat it as a new request subject to round-robin.
REQ-024 The block SHALL ignore requests arriving during RUN or DONE until IDLE.
REQ-025 The product SHALL be exact and never truncated: 2*WIDTH bits, no overflow possible.

Reset
REQ-026 While Reset=0 at a rising edge, the block SHALL enter IDLE and set oResult=0, oDone0=oDone1=0, oBusy=0, oOwner=0, last-served=1, and clear the accumulator and counter.
REQ-027 Reset asserted mid-RUN or mid-DONE SHALL abort the transaction with no oDone pulse.
REQ-028 Because last-served resets to 1, requester 0 SHALL win the first simultaneous request after reset.

Configuration
REQ-029 With macro MUL_ARBITER_SIGNED_EN defined, operands and result SHALL be two's complement.
- At grant: latch operand magnitudes and sign = sign(A) XOR sign(B).
- In DONE: negate the unsigned product when sign=1.
- The most negative operand SHALL be handled exactly, e.g. -32768 * -32768 = 0x40000000 at WIDTH=16.
REQ-030 Without MUL_ARBITER_SIGNED_EN, operands and result SHALL be unsigned and no sign logic SHALL be present.
REQ-031 Latency SHALL be identical in both configurations.

Verification (WIDTH=16)
REQ-032 The bench SHALL cover these directed scenarios:
- Reset, then iReq0=1 with A0=3, B0=5 -> oDone0 pulses once 17 edges after grant; oResult=0x0000000F; oDone1 stays 0.
- iReq0 and iReq1 high together after reset, A0=2 B0=2, A1=7 B1=6, both held -> requester 0 served first (oResult=4), then requester 1 (oResult=42, oOwner=1); back-to-back grants alternate.
- Unsigned build, A=0xFFFF B=0xFFFF -> oResult=0xFFFE0001; signed build, A=0xFFFF B=0x0003 -> oResult=0xFFFFFFFD.
- Change iA0 to 0 and drop iReq0 mid-RUN on a 9*9 transaction -> oResult=81 and oDone0 still pulses.
- Assert Reset=0 mid-RUN -> no oDone pulse, oBusy=0, oResult=0; next request completes normally.
- iReq1 held continuously while iReq0 idle -> successive transactions every 18 cycles, each pulsing oDone1.
